// File: rtl/cpu_player_pkg.sv
// Shared game package: computer-player state encoding, default timing
// parameters and small helpers used by the cpu_player blocks.
package cpu_player_pkg;

  // Width of the reaction/press tick counter.
  localparam int unsigned CNT_W  = 8;
  // Width of the difficulty selector.
  localparam int unsigned DIFF_W = 4;

  // Default timing, in slowen ticks.
  localparam int unsigned DEF_BASE_TICKS  = 8;
  localparam int unsigned DEF_STEP_TICKS  = 2;
  localparam int unsigned DEF_PRESS_TICKS = 4;

  // Computer-player round states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_REACT   = 3'd2,
    ST_PRESS   = 3'd3,
    ST_RELEASE = 3'd4
  } cpu_state_e;

  // Reaction delay: base + difficulty*step + jitter. With the defaults the
  // largest value is 8 + 15*2 + 3 = 41, far below the 8-bit counter limit.
  function automatic logic [CNT_W-1:0] react_delay(
    input logic [CNT_W-1:0]  base_ticks,
    input logic [CNT_W-1:0]  step_ticks,
    input logic [DIFF_W-1:0] difficulty,
    input logic [1:0]        jitter
  );
    logic [CNT_W-1:0] diff_ext;
    logic [CNT_W-1:0] jit_ext;
    diff_ext = CNT_W'(difficulty);
    jit_ext  = CNT_W'(jitter);
    return base_ticks + (step_ticks * diff_ext) + jit_ext;
  endfunction

  // The player counts as busy from the start of the reaction until the go
  // window closes.
  function automatic logic state_is_busy(input cpu_state_e s);
    return (s == ST_REACT) || (s == ST_PRESS) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/cpu_player_if.sv
// Control-side bundle between master game control and the computer player.
interface cpu_player_if;
  import cpu_player_pkg::*;

  logic              leds_on;     // go window: players may push
  logic              enable;      // computer opponent active
  logic [DIFF_W-1:0] difficulty;  // 0 = fastest, 15 = slowest
  logic              pb_out;      // emulated push-button level
  logic              busy;        // reacting, pressing or waiting for window end

  // Game control side.
  modport master (
    output leds_on,
    output enable,
    output difficulty,
    input  pb_out,
    input  busy
  );

  // Computer player side.
  modport slave (
    input  leds_on,
    input  enable,
    input  difficulty,
    output pb_out,
    output busy
  );

endinterface

// File: rtl/cpu_player_tick_counter.sv
// tick_counter: loadable down-counter with decrement enable, shared by the
// reaction delay and the button hold time. Load wins over decrement, and the
// count saturates at zero.
module cpu_player_tick_counter
  import cpu_player_pkg::*;
(
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] count,
  output logic             zero,      // count is 0
  output logic             last       // count is 1: next decrement expires
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: load has priority, otherwise decrement when enabled and non-zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == {CNT_W{1'b0}});
  assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: waits for the go window, waits a difficulty-dependent
// randomised number of slowen ticks, then holds an emulated push button for
// a fixed number of ticks. At most one press per go window.
module cpu_player
  import cpu_player_pkg::*;
#(
  parameter int unsigned BASE_TICKS  = DEF_BASE_TICKS,
  parameter int unsigned STEP_TICKS  = DEF_STEP_TICKS,
  parameter int unsigned PRESS_TICKS = DEF_PRESS_TICKS
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active-low
  input  logic         slowen,    // one-clk tick enable from the divide-by-256 divider
  input  logic         rand_bit,  // pseudo-random bit from the LFSR
  cpu_player_if.slave  bus
);

  cpu_state_e       state_d;
  cpu_state_e       state_q;
  logic [1:0]       jitter_d;
  logic [1:0]       jitter_q;
  logic             pb_out_d;
  logic             pb_out_q;
  logic             busy_d;
  logic             busy_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_zero;
  logic             cnt_last;
  logic             tick_done;

  // Jitter shifter: collects the two most recent random bits every clock.
  always_comb begin
    jitter_d = {jitter_q[0], rand_bit};
  end

  // Jitter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jitter_q <= 2'b00;
    end else begin
      jitter_q <= jitter_d;
    end
  end

  // A timed phase ends on the slowen tick that takes the counter to zero.
  // An already-zero counter (only possible with a zero load) ends on the
  // first tick so the FSM can never stall.
  assign tick_done = slowen && (cnt_last || cnt_zero);

  // Next state, counter control and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = {CNT_W{1'b0}};
    cnt_dec  = slowen && ((state_q == ST_REACT) || (state_q == ST_PRESS));

    if (!bus.enable) begin
      // Disabling the opponent overrides everything and clears the timer.
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
      cnt_val  = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (bus.leds_on) begin
            // Difficulty and jitter are captured here only.
            state_d  = ST_REACT;
            cnt_load = 1'b1;
            cnt_val  = react_delay(CNT_W'(BASE_TICKS), CNT_W'(STEP_TICKS),
                                   bus.difficulty, jitter_q);
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_REACT: begin
          if (!bus.leds_on) begin
            // Round already decided by someone else: never press.
            state_d = ST_RELEASE;
          end else if (tick_done) begin
            state_d  = ST_PRESS;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(PRESS_TICKS);
          end else begin
            state_d = ST_REACT;
          end
        end
        ST_PRESS: begin
          // The button hold ignores leds_on; only its own timer ends it.
          if (tick_done) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_PRESS;
          end
        end
        ST_RELEASE: begin
          if (!bus.leds_on) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_RELEASE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
          cnt_val  = {CNT_W{1'b0}};
        end
      endcase
    end

    // Outputs are derived from the next state so they switch on the same
    // edge as the state transition.
    pb_out_d = (state_d == ST_PRESS);
    busy_d   = state_is_busy(state_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pb_out_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pb_out_q <= pb_out_d;
      busy_q   <= busy_d;
    end
  end

  cpu_player_tick_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec_en   (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  assign bus.pb_out = pb_out_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_cpu_player.sv
// Scoreboard bench for cpu_player: stimulus pushes the expected output
// changes (pb_out, busy, slowen tick number) and a monitor pops and compares
// each time the DUT outputs change.
module tb_cpu_player;
  import cpu_player_pkg::*;

  typedef struct {
    string name;
    logic  pb;
    logic  busy;
    int    tick;
  } exp_t;

  logic clk;
  logic rst;
  logic slowen;
  logic rand_bit;
  int   tick_no;
  int   total;
  int   bad;
  exp_t exp_q[$];

  cpu_player_if bus ();

  cpu_player dut (
    .clk      (clk),
    .rst      (rst),
    .slowen   (slowen),
    .rand_bit (rand_bit),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic expect_ev(input string name, input logic pb, input logic busy, input int tick);
    exp_t e;
    e.name = name;
    e.pb   = pb;
    e.busy = busy;
    e.tick = tick;
    exp_q.push_back(e);
  endtask

  // One slowen pulse followed by two idle clocks; ends on a negedge.
  task automatic slow_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      slowen  = 1'b1;
      tick_no = tick_no + 1;
      @(negedge clk);
      slowen = 1'b0;
      @(negedge clk);
    end
  endtask

  // Open the go window on a negedge; slowen is pulsed in the same cycle
  // to show that the load cycle does not count as a tick.
  task automatic open_window();
    @(negedge clk);
    bus.leds_on = 1'b1;
    slowen      = 1'b1;
    tick_no     = 0;
    @(negedge clk);
    slowen = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited = waited + 1;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every output change must match the next expected event.
  initial begin : monitor
    logic prev_pb;
    logic prev_busy;
    exp_t e;
    prev_pb   = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pb_out !== prev_pb || bus.busy !== prev_busy) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_change: got pb=%0b busy=%0b at tick %0d, want no change",
                   bus.pb_out, bus.busy, tick_no);
        end else begin
          e = exp_q.pop_front();
          if (bus.pb_out !== e.pb || bus.busy !== e.busy || tick_no != e.tick) begin
            bad = bad + 1;
            $display("FAIL %s: got pb=%0b busy=%0b tick=%0d, want pb=%0b busy=%0b tick=%0d",
                     e.name, bus.pb_out, bus.busy, tick_no, e.pb, e.busy, e.tick);
          end
        end
        prev_pb   = bus.pb_out;
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : stimulus
    total          = 0;
    bad            = 0;
    tick_no        = 0;
    rst            = 1'b0;
    slowen         = 1'b0;
    rand_bit       = 1'b0;
    bus.leds_on    = 1'b0;
    bus.enable     = 1'b0;
    bus.difficulty = 4'd0;

    // Reset state.
    #12;
    check("rst_pb", 32'(bus.pb_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Disabled opponent ignores the go window.
    bus.leds_on = 1'b1;
    slow_tick(3);
    check("disabled_idle", 32'(dut.state_q), 32'(ST_IDLE));
    bus.leds_on = 1'b0;
    bus.enable  = 1'b1;
    repeat (3) @(negedge clk);
    check("armed_after_enable", 32'(dut.state_q), 32'(ST_ARMED));

    // difficulty 0, jitter 0: press on tick 8 for 4 ticks, one press in 100.
    expect_ev("t1_busy_on", 1'b0, 1'b1, 0);
    expect_ev("t1_pb_on", 1'b1, 1'b1, 8);
    expect_ev("t1_pb_off", 1'b0, 1'b1, 12);
    expect_ev("t1_busy_off", 1'b0, 1'b0, 100);
    open_window();
    slow_tick(100);
    bus.leds_on = 1'b0;
    drain("t1");

    // difficulty 15, jitter 3: press on tick 41; mid-REACT difficulty change ignored.
    bus.difficulty = 4'd15;
    rand_bit       = 1'b1;
    repeat (3) @(negedge clk);
    expect_ev("t2_busy_on", 1'b0, 1'b1, 0);
    expect_ev("t2_pb_on", 1'b1, 1'b1, 41);
    expect_ev("t2_pb_off", 1'b0, 1'b1, 45);
    expect_ev("t2_busy_off", 1'b0, 1'b0, 50);
    open_window();
    slow_tick(3);
    bus.difficulty = 4'd0;
    slow_tick(47);
    bus.leds_on = 1'b0;
    drain("t2");
    rand_bit = 1'b0;
    repeat (3) @(negedge clk);

    // Window closes after 5 ticks: no press, RELEASE then ARMED.
    expect_ev("t3_busy_on", 1'b0, 1'b1, 0);
    expect_ev("t3_busy_off", 1'b0, 1'b0, 5);
    open_window();
    slow_tick(5);
    bus.leds_on = 1'b0;
    @(posedge clk);
    #1;
    check("t3_release", 32'(dut.state_q), 32'(ST_RELEASE));
    @(posedge clk);
    #1;
    check("t3_armed", 32'(dut.state_q), 32'(ST_ARMED));
    slow_tick(10);
    drain("t3");

    // enable dropped during PRESS: pb_out and busy fall on the next edge.
    expect_ev("t4_busy_on", 1'b0, 1'b1, 0);
    expect_ev("t4_pb_on", 1'b1, 1'b1, 8);
    expect_ev("t4_disable", 1'b0, 1'b0, 8);
    open_window();
    slow_tick(8);
    check("t4_in_press", 32'(dut.state_q), 32'(ST_PRESS));
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check("t4_pb_low", 32'(bus.pb_out), 32'd0);
    check("t4_idle", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    bus.leds_on = 1'b0;
    bus.enable  = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_rearmed", 32'(dut.state_q), 32'(ST_ARMED));
    drain("t4");

    // Asynchronous reset mid-PRESS: pb_out drops without a clock edge.
    expect_ev("t5_busy_on", 1'b0, 1'b1, 0);
    expect_ev("t5_pb_on", 1'b1, 1'b1, 8);
    expect_ev("t5_reset", 1'b0, 1'b0, 8);
    open_window();
    slow_tick(8);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t5_async_pb", 32'(bus.pb_out), 32'd0);
    check("t5_async_busy", 32'(bus.busy), 32'd0);
    check("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t5_count", 32'(dut.cnt_count), 32'd0);
    check("t5_jitter", 32'(dut.jitter_q), 32'd0);
    @(negedge clk);
    bus.leds_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_restart_armed", 32'(dut.state_q), 32'(ST_ARMED));
    drain("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
